// File: rtl/snn_conv_pe_if.sv
// Packet interface of the spiking-CNN processing element: an input packet
// channel and an output packet channel, both valid/ready.
interface snn_conv_pe_if #(
    parameter int PKT_W = 29,
    parameter int OUT_W = 14
);
    // Both channels: a beat transfers on a rising clk edge where valid && ready.
    // A sender keeps valid and data stable until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/snn_conv_pe_seq.sv
// Sequential spiking-CNN processing element: loads a KxK filter, accumulates one
// binary window per timestep and fires on threshold. Optional leak: PE_LEAK_EN.
module snn_conv_pe_seq #(
    parameter int FILTER_WIDTH  = 8,
    parameter int KERNEL        = 3,
    parameter int NUM_TS        = 2,
    parameter int RESIDUE_WIDTH = 12,
    parameter int THRESHOLD     = 64,
    parameter int LEAK          = 1,
    parameter int TS_W          = $clog2(NUM_TS),
    parameter int ROW_W         = $clog2(KERNEL) + 1,
    parameter int PAYLOAD_W     = (KERNEL*FILTER_WIDTH > KERNEL*KERNEL) ?
                                  KERNEL*FILTER_WIDTH : KERNEL*KERNEL,
    parameter int PKT_W         = PAYLOAD_W + 1 + ROW_W + TS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    snn_conv_pe_if.slave pe,
    output logic         err_ts,
    output logic [2:0]   dbg_state
);
    localparam int TAPS  = KERNEL * KERNEL;
    localparam int TAP_W = $clog2(TAPS + 1);
    localparam logic [RESIDUE_WIDTH-1:0] RES_MAX = '1;
    localparam logic [RESIDUE_WIDTH-1:0] THR     = RESIDUE_WIDTH'(THRESHOLD);

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACC  = 3'd2,
        ST_FIRE = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    state_t                    state;
    logic [KERNEL-1:0]         mask;
    logic [FILTER_WIDTH-1:0]   weights [TAPS];
    logic [TAPS-1:0]           spikes;
    logic [TAP_W-1:0]          tap;
    logic [RESIDUE_WIDTH-1:0]  acc;
    logic [RESIDUE_WIDTH-1:0]  residue;
    logic [TS_W-1:0]           exp_ts;
    logic [TS_W-1:0]           cur_ts;

    logic [TS_W-1:0]           pkt_ts;
    logic [ROW_W-1:0]          pkt_row;
    logic                      pkt_filter;
    logic [PAYLOAD_W-1:0]      pkt_payload;
    logic                      in_fire;
    logic [KERNEL-1:0]         row_bit;
    logic                      row_ok;
    logic [RESIDUE_WIDTH:0]    acc_sum;
    logic [RESIDUE_WIDTH-1:0]  acc_next;
    logic [RESIDUE_WIDTH-1:0]  residue_in;
    logic [RESIDUE_WIDTH:0]    v_sum;
    logic [RESIDUE_WIDTH-1:0]  v_sat;
    logic                      fire;
    logic [RESIDUE_WIDTH-1:0]  res_next;

    assign pkt_ts      = pe.in_data[TS_W-1:0];
    assign pkt_row     = pe.in_data[TS_W +: ROW_W];
    assign pkt_filter  = pe.in_data[TS_W+ROW_W];
    assign pkt_payload = pe.in_data[PKT_W-1 -: PAYLOAD_W];
    assign in_fire     = pe.in_valid && pe.in_ready;
    assign dbg_state   = state;

    // One-hot row decode; rows outside 1..K decode to zero and are dropped.
    always_comb begin
        row_bit = '0;
        for (int r = 0; r < KERNEL; r++) begin
            row_bit[r] = (pkt_row == ROW_W'(r + 1));
        end
        row_ok = |row_bit;
    end

    always_comb begin
        acc_sum  = {1'b0, acc} + (RESIDUE_WIDTH+1)'(weights[tap]);
        acc_next = acc;
        if (spikes[tap]) begin
            acc_next = acc_sum[RESIDUE_WIDTH] ? RES_MAX : acc_sum[RESIDUE_WIDTH-1:0];
        end
    end

    // The first timestep of an inference starts from an empty membrane.
`ifdef PE_LEAK_EN
    localparam logic [RESIDUE_WIDTH-1:0] LEAK_R = RESIDUE_WIDTH'(LEAK);
    always_comb begin
        residue_in = '0;
        if (cur_ts != '0) begin
            residue_in = (residue >= LEAK_R) ? residue - LEAK_R : '0;
        end
    end
`else
    logic unused_leak;
    assign unused_leak = (LEAK != 0);
    always_comb begin
        residue_in = '0;
        if (cur_ts != '0) begin
            residue_in = residue;
        end
    end
`endif

    always_comb begin
        v_sum    = {1'b0, residue_in} + {1'b0, acc};
        v_sat    = v_sum[RESIDUE_WIDTH] ? RES_MAX : v_sum[RESIDUE_WIDTH-1:0];
        fire     = (v_sat >= THR);
        res_next = fire ? v_sat - THR : v_sat;
    end

    // Weight storage needs no reset: the row mask gates its use.
    always_ff @(posedge clk) begin
        if (in_fire && pkt_filter) begin
            for (int r = 0; r < KERNEL; r++) begin
                if (row_bit[r]) begin
                    for (int c = 0; c < KERNEL; c++) begin
                        weights[r*KERNEL + c] <=
                            pkt_payload[(KERNEL-c)*FILTER_WIDTH-1 -: FILTER_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            mask         <= '0;
            spikes       <= '0;
            tap          <= '0;
            acc          <= '0;
            residue      <= '0;
            exp_ts       <= '0;
            cur_ts       <= '0;
            pe.in_ready  <= 1'b1;
            pe.out_valid <= 1'b0;
            pe.out_data  <= '0;
            err_ts       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (!pkt_filter) begin
                            err_ts <= 1'b1;
                        end else if (row_ok) begin
                            mask <= mask | row_bit;
                            if ((mask | row_bit) == '1) begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (in_fire) begin
                        if (pkt_filter) begin
                            // A new filter row starts a fresh inference.
                            if (row_ok) begin
                                mask    <= row_bit;
                                residue <= '0;
                                exp_ts  <= '0;
                                state   <= (row_bit == '1) ? ST_WAIT : ST_LOAD;
                            end
                        end else if (pkt_ts == exp_ts) begin
                            spikes      <= pkt_payload[TAPS-1:0];
                            cur_ts      <= pkt_ts;
                            acc         <= '0;
                            tap         <= '0;
                            pe.in_ready <= 1'b0;
                            state       <= ST_ACC;
                        end else begin
                            err_ts <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    acc <= acc_next;
                    if (tap == TAP_W'(TAPS - 1)) begin
                        state <= ST_FIRE;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                ST_FIRE: begin
                    residue      <= res_next;
                    pe.out_data  <= {res_next, fire, cur_ts};
                    pe.out_valid <= 1'b1;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (pe.out_valid && pe.out_ready) begin
                        pe.out_valid <= 1'b0;
                        exp_ts       <= (cur_ts == TS_W'(NUM_TS - 1)) ? '0 : cur_ts + 1'b1;
                        pe.in_ready  <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule
